down_counter_sequencer: RTL and testbench

Controller that sequences a mod-N, N-bit down counter under a start/pause/abort handshake. Each accepted command latches a modulus M and a repetition count R. The block then counts M-1 down to 0, R times, and flags every wrap and the end of the run. It sits between a host/control FSM and any logic that needs timed down-count windows, and replaces free-running mod-N counters wherever start/stop control is required.

---
 rtl/down_counter_sequencer.sv | 135 +++++++++++++
 tb/tb_down_counter_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/down_counter_sequencer.sv
// down_counter_sequencer
// Start/pause/abort controller around a mod-M down counter that runs R periods.
// A command latches modulus M and repetition count R; the counter walks
// M-1..0 R times, pulsing Tick at each wrap and Done at the end of the run.
// Optional feature macro: DNCTR_AUTO_RELOAD_EN (Reps=0 selects free-running
// mode that only Abort or reset can end). Without it Reps=0 behaves as R=1.
module down_counter_sequencer #(
  parameter int Bit  = 4,
  parameter int RepW = 4
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            Start,
  input  logic [Bit-1:0]  Load_val,
  input  logic [RepW-1:0] Reps,
  input  logic            Pause,
  input  logic            Abort,
  output logic [Bit-1:0]  Counter,
  output logic            Busy,
  output logic            Tick,
  output logic            Done,
  output logic            Err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [Bit-1:0]  CNT_ONE = {{(Bit-1){1'b0}}, 1'b1};
  localparam logic [RepW-1:0] REP_ONE = {{(RepW-1){1'b0}}, 1'b1};

  state_t          state;
  logic [Bit-1:0]  m_reg;     // latched modulus M
  logic [RepW-1:0] rrem;      // periods remaining, including the current one
  logic            free_run;  // wrap forever, never finish on its own

  // Single-process FSM; every output is a register updated alongside the state.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state    <= IDLE;
      m_reg    <= '0;
      rrem     <= '0;
      free_run <= 1'b0;
      Counter  <= '0;
      Busy     <= 1'b0;
      Tick     <= 1'b0;
      Done     <= 1'b0;
      Err      <= 1'b0;
    end else begin
      // Pulses default low; only the branches below raise them for one cycle.
      Tick <= 1'b0;
      Done <= 1'b0;
      Err  <= 1'b0;

      case (state)
        IDLE: begin
          Counter <= '0;
          Busy    <= 1'b0;
          if (Start) begin
            if (Load_val == '0) begin
              // A zero modulus has no valid count window: reject, latch nothing.
              Err <= 1'b1;
            end else begin
              m_reg   <= Load_val;
              Counter <= Load_val - CNT_ONE;
              Busy    <= 1'b1;
              state   <= RUN;
`ifdef DNCTR_AUTO_RELOAD_EN
              free_run <= (Reps == '0);
              rrem     <= Reps;
`else
              free_run <= 1'b0;
              rrem     <= (Reps == '0) ? REP_ONE : Reps;
`endif
            end
          end
        end

        RUN, HOLD: begin
          if (Abort) begin
            // Cancel silently: no Tick, Done or Err for an aborted run.
            state    <= IDLE;
            Counter  <= '0;
            rrem     <= '0;
            free_run <= 1'b0;
            Busy     <= 1'b0;
          end else if (Pause) begin
            // Freeze counter and remaining periods; a pause costs one cycle each.
            state <= HOLD;
            Busy  <= 1'b1;
          end else begin
            // Counting edge; a HOLD release behaves exactly like a RUN edge.
            state <= RUN;
            Busy  <= 1'b1;
            if (Counter != '0) begin
              Counter <= Counter - CNT_ONE;
            end else if (free_run || (rrem > REP_ONE)) begin
              // Period complete with more to go: reload and flag the wrap.
              Counter <= m_reg - CNT_ONE;
              Tick    <= 1'b1;
              if (!free_run) begin
                rrem <= rrem - REP_ONE;
              end
            end else begin
              // Last period complete: final Tick and Done land together in DONE.
              Counter <= '0;
              rrem    <= '0;
              Tick    <= 1'b1;
              Done    <= 1'b1;
              Busy    <= 1'b0;
              state   <= DONE;
            end
          end
        end

        DONE: begin
          // One-cycle completion state; Start is not looked at here.
          Counter <= '0;
          Busy    <= 1'b0;
          state   <= IDLE;
        end

        default: begin
          Counter <= '0;
          Busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_down_counter_sequencer.sv
// Testbench for down_counter_sequencer: directed scenarios plus randomized
// runs, all checked against a trace-level model of the count sequence.
module tb_down_counter_sequencer;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       Start;
  logic [3:0] Load_val;
  logic [3:0] Reps;
  logic       Pause;
  logic       Abort;
  logic [3:0] Counter;
  logic       Busy, Tick, Done, Err;

  int n_chk = 0;
  int n_fail = 0;

  // Per-cycle stimulus for a run, indexed by cycle since the accepting edge.
  bit pz[1024];
  bit ab[1024];

  // Expected and observed per-cycle traces.
  logic [3:0] exp_cnt[$];
  logic       exp_busy[$], exp_tick[$], exp_done[$];
  logic [3:0] obs_cnt[$];
  logic       obs_busy[$], obs_tick[$], obs_done[$], obs_err[$];

  down_counter_sequencer #(.Bit(4), .RepW(4)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Load_val(Load_val), .Reps(Reps),
    .Pause(Pause), .Abort(Abort), .Counter(Counter), .Busy(Busy),
    .Tick(Tick), .Done(Done), .Err(Err)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_stim();
    for (int i = 0; i < 1024; i++) begin
      pz[i] = 1'b0;
      ab[i] = 1'b0;
    end
  endtask

  task automatic push(input logic [3:0] c, input logic b, input logic t, input logic d);
    exp_cnt.push_back(c);
    exp_busy.push_back(b);
    exp_tick.push_back(t);
    exp_done.push_back(d);
  endtask

  // Reference: the run is a flat list of M*R values (M-1..0 repeated R times).
  // Each unpaused cycle advances one position; a Tick follows every cycle that
  // consumed a 0. Running off the end yields DONE, then IDLE.
  task automatic build_model(input int m, input int r);
    int  idx, lim;
    bit  tk, free;
    exp_cnt.delete(); exp_busy.delete(); exp_tick.delete(); exp_done.delete();
    free = 1'b0;
    lim  = r;
    if (r == 0) begin
`ifdef DNCTR_AUTO_RELOAD_EN
      free = 1'b1;
`else
      lim = 1;
`endif
    end
    idx = 0;
    tk  = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      if (!free && idx == m * lim) begin
        push(4'd0, 1'b0, 1'b1, 1'b1);
        push(4'd0, 1'b0, 1'b0, 1'b0);
        return;
      end
      push(4'(m - 1 - (idx % m)), 1'b1, tk, 1'b0);
      if (ab[c]) begin
        push(4'd0, 1'b0, 1'b0, 1'b0);
        return;
      end
      if (pz[c]) tk = 1'b0;
      else begin
        tk = ((idx % m) == m - 1);
        idx++;
      end
    end
  endtask

  // Issues one command and records outputs for as many cycles as the model
  // predicts, ending in the first IDLE cycle. With noise, Start and Load_val
  // are toggled during the run and must be ignored.
  task automatic run_cmd(input int m, input int r, input bit noise);
    obs_cnt.delete(); obs_busy.delete(); obs_tick.delete(); obs_done.delete(); obs_err.delete();
    Start = 1'b1; Load_val = 4'(m); Reps = 4'(r);
    step();
    Start = 1'b0;
    for (int c = 0; c < exp_cnt.size(); c++) begin
      obs_cnt.push_back(Counter);
      obs_busy.push_back(Busy);
      obs_tick.push_back(Tick);
      obs_done.push_back(Done);
      obs_err.push_back(Err);
      if (c == exp_cnt.size() - 1) break;
      Pause = pz[c];
      Abort = ab[c];
      if (noise) begin
        Start    = 1'($urandom_range(0, 1));
        Load_val = 4'($urandom_range(0, 15));
        Reps     = 4'($urandom_range(0, 15));
      end
      step();
    end
    Pause = 1'b0; Abort = 1'b0; Start = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b0; Start = 1'b1; Load_val = 4'd9; Reps = 4'd2; Pause = 1'b0; Abort = 1'b0;
    step(); step();
    n_chk++;
    if ({Counter, Busy, Tick, Done, Err} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset: got cnt=%0d busy=%b tick=%b done=%b err=%b, want all 0", Counter, Busy, Tick, Done, Err);
    end
    Rst = 1'b1; Start = 1'b0;
    step();
    n_chk++;
    if ({Counter, Busy, Tick, Done, Err} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_release: got cnt=%0d busy=%b tick=%b done=%b err=%b, want all 0", Counter, Busy, Tick, Done, Err);
    end
  endtask

  task automatic test_basic();
    int nb;
    clear_stim();
    build_model(9, 2);
    run_cmd(9, 2, 1'b0);
    for (int i = 0; i < exp_cnt.size(); i++) begin
      n_chk++;
      if (obs_cnt[i] !== exp_cnt[i] || obs_busy[i] !== exp_busy[i] || obs_tick[i] !== exp_tick[i] ||
          obs_done[i] !== exp_done[i] || obs_err[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL basic cyc %0d: got cnt=%0d busy=%b tick=%b done=%b err=%b, want cnt=%0d busy=%b tick=%b done=%b err=0",
                 i, obs_cnt[i], obs_busy[i], obs_tick[i], obs_done[i], obs_err[i], exp_cnt[i], exp_busy[i], exp_tick[i], exp_done[i]);
      end
    end
    nb = 0;
    foreach (obs_busy[i]) if (obs_busy[i] === 1'b1) nb++;
    n_chk++;
    if (nb != 18) begin
      n_fail++;
      $display("FAIL basic_busy_len: got %0d busy cycles, want 18", nb);
    end
    n_chk++;
    if (obs_tick[9] !== 1'b1 || obs_tick[18] !== 1'b1 || obs_done[18] !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_tick_pos: got tick9=%b tick18=%b done18=%b, want 1 1 1", obs_tick[9], obs_tick[18], obs_done[18]);
    end
  endtask

  task automatic test_err();
    Start = 1'b1; Load_val = 4'd0; Reps = 4'd3;
    step();
    Start = 1'b0;
    n_chk++;
    if (Err !== 1'b1 || Busy !== 1'b0 || Counter !== 4'd0) begin
      n_fail++;
      $display("FAIL err_pulse: got err=%b busy=%b cnt=%0d, want err=1 busy=0 cnt=0", Err, Busy, Counter);
    end
    step();
    n_chk++;
    if (Err !== 1'b0 || Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL err_single: got err=%b busy=%b, want err=0 busy=0", Err, Busy);
    end
  endtask

  task automatic test_mod1();
    clear_stim();
    build_model(1, 3);
    run_cmd(1, 3, 1'b0);
    for (int i = 0; i < exp_cnt.size(); i++) begin
      n_chk++;
      if (obs_cnt[i] !== exp_cnt[i] || obs_busy[i] !== exp_busy[i] || obs_tick[i] !== exp_tick[i] ||
          obs_done[i] !== exp_done[i] || obs_err[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL mod1 cyc %0d: got cnt=%0d busy=%b tick=%b done=%b err=%b, want cnt=%0d busy=%b tick=%b done=%b err=0",
                 i, obs_cnt[i], obs_busy[i], obs_tick[i], obs_done[i], obs_err[i], exp_cnt[i], exp_busy[i], exp_tick[i], exp_done[i]);
      end
    end
  endtask

  task automatic test_pause();
    clear_stim();
    pz[2] = 1'b1; pz[3] = 1'b1; pz[4] = 1'b1;  // cycles where Counter sits at 2
    build_model(5, 1);
    run_cmd(5, 1, 1'b0);
    for (int i = 0; i < exp_cnt.size(); i++) begin
      n_chk++;
      if (obs_cnt[i] !== exp_cnt[i] || obs_busy[i] !== exp_busy[i] || obs_tick[i] !== exp_tick[i] ||
          obs_done[i] !== exp_done[i] || obs_err[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL pause cyc %0d: got cnt=%0d busy=%b tick=%b done=%b err=%b, want cnt=%0d busy=%b tick=%b done=%b err=0",
                 i, obs_cnt[i], obs_busy[i], obs_tick[i], obs_done[i], obs_err[i], exp_cnt[i], exp_busy[i], exp_tick[i], exp_done[i]);
      end
    end
    n_chk++;
    if (obs_done.size() != 10 || obs_done[8] !== 1'b1) begin
      n_fail++;
      $display("FAIL pause_done_delay: got len=%0d, want done at cycle 8 of 10", obs_done.size());
    end
  endtask

  task automatic test_abort();
    clear_stim();
    ab[13] = 1'b1;  // second period, Counter=4
    build_model(9, 4);
    run_cmd(9, 4, 1'b0);
    for (int i = 0; i < exp_cnt.size(); i++) begin
      n_chk++;
      if (obs_cnt[i] !== exp_cnt[i] || obs_busy[i] !== exp_busy[i] || obs_tick[i] !== exp_tick[i] ||
          obs_done[i] !== exp_done[i] || obs_err[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL abort cyc %0d: got cnt=%0d busy=%b tick=%b done=%b err=%b, want cnt=%0d busy=%b tick=%b done=%b err=0",
                 i, obs_cnt[i], obs_busy[i], obs_tick[i], obs_done[i], obs_err[i], exp_cnt[i], exp_busy[i], exp_tick[i], exp_done[i]);
      end
    end
    // Abort together with Pause while already in HOLD.
    clear_stim();
    pz[3] = 1'b1; pz[4] = 1'b1; pz[5] = 1'b1; ab[5] = 1'b1;
    build_model(6, 2);
    run_cmd(6, 2, 1'b0);
    for (int i = 0; i < exp_cnt.size(); i++) begin
      n_chk++;
      if (obs_cnt[i] !== exp_cnt[i] || obs_busy[i] !== exp_busy[i] || obs_tick[i] !== exp_tick[i] ||
          obs_done[i] !== exp_done[i] || obs_err[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_hold cyc %0d: got cnt=%0d busy=%b tick=%b done=%b err=%b, want cnt=%0d busy=%b tick=%b done=%b err=0",
                 i, obs_cnt[i], obs_busy[i], obs_tick[i], obs_done[i], obs_err[i], exp_cnt[i], exp_busy[i], exp_tick[i], exp_done[i]);
      end
    end
  endtask

  task automatic test_reset_midrun();
    Start = 1'b1; Load_val = 4'd9; Reps = 4'd1;
    step();
    Start = 1'b0;
    step(); step();
    n_chk++;
    if (Counter !== 4'd6 || Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun_pre: got cnt=%0d busy=%b, want cnt=6 busy=1", Counter, Busy);
    end
    Rst = 1'b0; Start = 1'b1; Pause = 1'b1; Abort = 1'b1;
    step();
    n_chk++;
    if ({Counter, Busy, Tick, Done, Err} !== 8'h00) begin
      n_fail++;
      $display("FAIL midrun_reset: got cnt=%0d busy=%b tick=%b done=%b err=%b, want all 0", Counter, Busy, Tick, Done, Err);
    end
    Rst = 1'b1; Start = 1'b0; Pause = 1'b0; Abort = 1'b0;
    step();
    n_chk++;
    if (Busy !== 1'b0 || Counter !== 4'd0) begin
      n_fail++;
      $display("FAIL midrun_idle: got cnt=%0d busy=%b, want cnt=0 busy=0", Counter, Busy);
    end
  endtask

  // Start pulses mid-run are ignored; each run also begins in the IDLE cycle
  // right after the previous DONE, so these runs are back-to-back.
  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) begin
      clear_stim();
      build_model(7, 2);
      run_cmd(7, 2, 1'b1);
      for (int i = 0; i < exp_cnt.size(); i++) begin
        n_chk++;
        if (obs_cnt[i] !== exp_cnt[i] || obs_busy[i] !== exp_busy[i] || obs_tick[i] !== exp_tick[i] ||
            obs_done[i] !== exp_done[i] || obs_err[i] !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b run %0d cyc %0d: got cnt=%0d busy=%b tick=%b done=%b err=%b, want cnt=%0d busy=%b tick=%b done=%b err=0",
                   k, i, obs_cnt[i], obs_busy[i], obs_tick[i], obs_done[i], obs_err[i], exp_cnt[i], exp_busy[i], exp_tick[i], exp_done[i]);
        end
      end
    end
  endtask

  task automatic test_reps0();
    clear_stim();
    ab[36] = 1'b1;  // twelve periods of 3, then abort (only reached in free-running builds)
    build_model(3, 0);
    run_cmd(3, 0, 1'b0);
    for (int i = 0; i < exp_cnt.size(); i++) begin
      n_chk++;
      if (obs_cnt[i] !== exp_cnt[i] || obs_busy[i] !== exp_busy[i] || obs_tick[i] !== exp_tick[i] ||
          obs_done[i] !== exp_done[i] || obs_err[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL reps0 cyc %0d: got cnt=%0d busy=%b tick=%b done=%b err=%b, want cnt=%0d busy=%b tick=%b done=%b err=0",
                 i, obs_cnt[i], obs_busy[i], obs_tick[i], obs_done[i], obs_err[i], exp_cnt[i], exp_busy[i], exp_tick[i], exp_done[i]);
      end
    end
  endtask

  task automatic test_random();
    int m, r, span;
    for (int k = 0; k < 25; k++) begin
      clear_stim();
      m = $urandom_range(1, 15);
      r = $urandom_range(0, 15);
      span = m * ((r == 0) ? 1 : r);
      for (int c = 0; c < 600; c++) pz[c] = ($urandom_range(0, 3) == 0);
      if (r == 0) ab[$urandom_range(0, 150)] = 1'b1;
      else if ($urandom_range(0, 3) == 0) ab[$urandom_range(0, span)] = 1'b1;
      build_model(m, r);
      run_cmd(m, r, 1'b1);
      for (int i = 0; i < exp_cnt.size(); i++) begin
        n_chk++;
        if (obs_cnt[i] !== exp_cnt[i] || obs_busy[i] !== exp_busy[i] || obs_tick[i] !== exp_tick[i] ||
            obs_done[i] !== exp_done[i] || obs_err[i] !== 1'b0) begin
          n_fail++;
          $display("FAIL random run %0d (M=%0d R=%0d) cyc %0d: got cnt=%0d busy=%b tick=%b done=%b err=%b, want cnt=%0d busy=%b tick=%b done=%b err=0",
                   k, m, r, i, obs_cnt[i], obs_busy[i], obs_tick[i], obs_done[i], obs_err[i], exp_cnt[i], exp_busy[i], exp_tick[i], exp_done[i]);
        end
      end
      if ($urandom_range(0, 1) == 1) step();  // vary the idle gap
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_err();
    test_mod1();
    test_pause();
    test_abort();
    test_reset_midrun();
    test_back_to_back();
    test_reps0();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
